// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - shared types and constants for the MD5 digest TX sequencer
package md5_pkg;

   localparam int DIGEST_W = 128;

   localparam logic [7:0] ASCII_0    = 8'h30;
   localparam logic [7:0] ASCII_A_LC = 8'h61;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
      WAIT_START,
      WAIT_DONE
   } tx_state_t;

   // Number of characters put on the wire for one digest.
   function automatic int char_count(input int hex_mode, input int append_crlf);
      return ((hex_mode != 0) ? 32 : 16) + ((append_crlf != 0) ? 2 : 0);
   endfunction

endpackage

// File: rtl/md5_hex_char.sv
// rtl/md5_hex_char.sv - nibble to lowercase ASCII hex digit
module md5_hex_char
   import md5_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   // 0-9 map onto '0'..'9', 10-15 onto 'a'..'f'
   always_comb begin
      ascii = 8'h00;
      if (nibble < 4'd10) begin
         ascii = ASCII_0 + {4'h0, nibble};
      end else begin
         ascii = ASCII_A_LC + {4'h0, nibble} - 8'd10;
      end
   end

endmodule

// File: rtl/md5_digest_tx_sequencer.sv
// rtl/md5_digest_tx_sequencer.sv - sends a captured MD5 digest byte by byte over the UART TX handshake
module md5_digest_tx_sequencer
   import md5_pkg::*;
#(
   parameter int HEX_MODE      = 1,
   parameter int APPEND_CRLF   = 1,
   parameter int START_TIMEOUT = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                digest_valid,
   input  logic [DIGEST_W-1:0] digest,
   input  logic                is_transmitting,
   output logic                ready,
   output logic                transmit,
   output logic [7:0]          tx_byte,
   output logic                busy,
   output logic                done,
   output logic                overrun
);

   localparam int N_DIGEST_CHARS = (HEX_MODE != 0) ? 32 : 16;
   localparam int N_CHARS        = char_count(HEX_MODE, APPEND_CRLF);
   localparam int TIMEOUT_CYC    = (START_TIMEOUT > 0) ? START_TIMEOUT : 1;
   localparam int TO_W           = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [5:0]      LAST_IDX = 6'(N_CHARS - 1);
   localparam logic [5:0]      CR_IDX   = 6'(N_DIGEST_CHARS);
   localparam logic [5:0]      LF_IDX   = 6'(N_DIGEST_CHARS + 1);
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

   tx_state_t           state;
   logic [DIGEST_W-1:0] digest_q;
   logic [5:0]          index;
   logic [TO_W-1:0]     to_cnt;

   logic [3:0]          nibble;
   logic [7:0]          raw_byte;
   logic [7:0]          hex_ascii;
   logic [7:0]          next_char;

   // Pick the nibble and the byte addressed by index; first on the wire is the MSB end
   always_comb begin
      nibble   = 4'h0;
      raw_byte = 8'h00;
      for (int k = 0; k < 32; k++) begin
         if (index == 6'(k)) begin
            nibble = digest_q[DIGEST_W-1-4*k -: 4];
         end
      end
      for (int k = 0; k < 16; k++) begin
         if (index == 6'(k)) begin
            raw_byte = digest_q[DIGEST_W-1-8*k -: 8];
         end
      end
   end

   md5_hex_char u_hex_char (
      .nibble (nibble),
      .ascii  (hex_ascii)
   );

   // Character for the current index: CR/LF trailer, else hex digit or raw byte
   always_comb begin
      next_char = 8'h00;
      if ((APPEND_CRLF != 0) && (index == CR_IDX)) begin
         next_char = ASCII_CR;
      end else if ((APPEND_CRLF != 0) && (index == LF_IDX)) begin
         next_char = ASCII_LF;
      end else if (HEX_MODE != 0) begin
         next_char = hex_ascii;
      end else begin
         next_char = raw_byte;
      end
   end

   // Transfer FSM; every output is registered so transmit is a clean single-cycle pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         ready    <= 1'b1;
         transmit <= 1'b0;
         tx_byte  <= 8'h00;
         busy     <= 1'b0;
         done     <= 1'b0;
         overrun  <= 1'b0;
         index    <= 6'd0;
         digest_q <= '0;
         to_cnt   <= '0;
      end else begin
         transmit <= 1'b0;
         done     <= 1'b0;
         // ready is only ever high in IDLE, so any strobe seen while low is lost
         overrun  <= digest_valid && !ready;

         case (state)
            IDLE: begin
               // ready stays low for the done cycle itself and recovers one cycle later
               if (!ready) begin
                  ready <= 1'b1;
               end else if (digest_valid) begin
                  digest_q <= digest;
                  index    <= 6'd0;
                  busy     <= 1'b1;
                  ready    <= 1'b0;
                  state    <= LOAD;
               end
            end

            LOAD: begin
               tx_byte <= next_char;
               // Never start a byte on top of one the UART is still shifting out
               if (!is_transmitting) begin
                  transmit <= 1'b1;
                  state    <= SEND;
               end
            end

            SEND: begin
               to_cnt <= '0;
               state  <= WAIT_START;
            end

            WAIT_START: begin
               // A UART that never acknowledges must not stall the sequencer forever
               if (is_transmitting) begin
                  state <= WAIT_DONE;
               end else if (to_cnt == TO_LAST) begin
                  state <= WAIT_DONE;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end

            WAIT_DONE: begin
               if (!is_transmitting) begin
                  if (index == LAST_IDX) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     index <= index + 6'd1;
                     state <= LOAD;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md5_digest_tx_sequencer.sv
// tb/tb_md5_digest_tx_sequencer.sv - randomized bench with a byte-stream reference model for the digest TX sequencer
module tb_md5_digest_tx_sequencer;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         digest_valid = 1'b0;
   logic [127:0] digest = '0;

   logic         is_tx    [2] = '{1'b0, 1'b0};
   logic         ready    [2];
   logic         transmit [2];
   logic [7:0]   tx_byte  [2];
   logic         busy     [2];
   logic         done     [2];
   logic         overrun  [2];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   md5_digest_tx_sequencer #(.HEX_MODE(1), .APPEND_CRLF(1), .START_TIMEOUT(4)) u_hex (
      .clk             (clk),
      .reset           (reset),
      .digest_valid    (digest_valid),
      .digest          (digest),
      .is_transmitting (is_tx[0]),
      .ready           (ready[0]),
      .transmit        (transmit[0]),
      .tx_byte         (tx_byte[0]),
      .busy            (busy[0]),
      .done            (done[0]),
      .overrun         (overrun[0])
   );

   md5_digest_tx_sequencer #(.HEX_MODE(0), .APPEND_CRLF(0), .START_TIMEOUT(4)) u_raw (
      .clk             (clk),
      .reset           (reset),
      .digest_valid    (digest_valid),
      .digest          (digest),
      .is_transmitting (is_tx[1]),
      .ready           (ready[1]),
      .transmit        (transmit[1]),
      .tx_byte         (tx_byte[1]),
      .busy            (busy[1]),
      .done            (done[1]),
      .overrun         (overrun[1])
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // UART model: busy for ulen cycles after each transmit, or forced/never-rising
   int ucnt [2] = '{0, 0};
   int ulen = 10;
   bit rand_len = 1'b0;
   bit never_rise = 1'b0;
   bit force_busy = 1'b0;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (force_busy) begin
            is_tx[i] <= 1'b1;
            ucnt[i]  <= 0;
         end else if (transmit[i] && !never_rise) begin
            is_tx[i] <= 1'b1;
            ucnt[i]  <= rand_len ? int'($urandom_range(1, 12)) : ulen;
         end else if (ucnt[i] > 1) begin
            ucnt[i]  <= ucnt[i] - 1;
         end else begin
            is_tx[i] <= 1'b0;
            ucnt[i]  <= 0;
         end
      end
   end

   // Reference model: expected byte stream per accepted digest plus handshake rules
   int           cyc = 0;
   bit           m_active    [2];
   int           m_pos       [2];
   int           m_len       [2];
   byte unsigned m_exp       [2][40];
   bit           m_prev_rdy  [2] = '{1'b1, 1'b1};
   bit           m_first     [2];
   int           m_expect_at [2];
   int           m_last      [2];
   bit           m_prev_dv = 1'b0;
   logic [127:0] m_prev_dig = '0;

   int           pulses   [2];
   int           dones    [2];
   int           overruns [2];
   byte unsigned rx       [2][40];

   function automatic void load_exp(input int i, input logic [127:0] d);
      string s;
      if (i == 0) begin
         s = $sformatf("%032h\r\n", d);
         m_len[i] = s.len();
         for (int k = 0; k < s.len(); k++) m_exp[i][k] = s[k];
      end else begin
         m_len[i] = 16;
         for (int k = 0; k < 16; k++) m_exp[i][k] = d[127-8*k -: 8];
      end
   endfunction

   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
         bit exp_ovr;
         bit rdy_exp;
         if (!reset) begin
            chk($sformatf("rst_ready[%0d]", i), 64'(ready[i]), 64'd1);
            chk($sformatf("rst_transmit[%0d]", i), 64'(transmit[i]), 64'd0);
            chk($sformatf("rst_tx_byte[%0d]", i), 64'(tx_byte[i]), 64'd0);
            chk($sformatf("rst_busy[%0d]", i), 64'(busy[i]), 64'd0);
            m_active[i]   = 1'b0;
            m_prev_rdy[i] = 1'b1;
            m_first[i]    = 1'b0;
         end else begin
            exp_ovr = m_prev_dv && !m_prev_rdy[i];
            if (m_prev_dv && m_prev_rdy[i]) begin
               load_exp(i, m_prev_dig);
               m_active[i]    = 1'b1;
               m_pos[i]       = 0;
               m_first[i]     = 1'b1;
               m_expect_at[i] = -1;
            end
            if (done[i]) begin
               chk($sformatf("done_in_transfer[%0d]", i), 64'(m_active[i]), 64'd1);
               chk($sformatf("done_all_sent[%0d]", i), 64'(m_pos[i]), 64'(m_len[i]));
               m_active[i] = 1'b0;
               dones[i]++;
            end
            chk($sformatf("overrun[%0d]", i), 64'(overrun[i]), 64'(exp_ovr));
            if (overrun[i]) overruns[i]++;
            chk($sformatf("busy[%0d]", i), 64'(busy[i]), 64'(m_active[i]));
            rdy_exp = !m_active[i] && !done[i];
            chk($sformatf("ready[%0d]", i), 64'(ready[i]), 64'(rdy_exp));
            if (transmit[i]) begin
               chk($sformatf("tx_while_busy[%0d]", i), 64'(is_tx[i]), 64'd0);
               chk($sformatf("tx_in_transfer[%0d]", i), 64'(m_active[i] && m_pos[i] < m_len[i]), 64'd1);
               if (m_pos[i] < 40) begin
                  chk($sformatf("tx_byte[%0d] char %0d", i, m_pos[i]), 64'(tx_byte[i]), 64'(m_exp[i][m_pos[i]]));
                  rx[i][m_pos[i]] = tx_byte[i];
               end
               if (m_first[i]) begin
                  chk($sformatf("first_tx_latency[%0d]", i), 64'(cyc), 64'(m_expect_at[i]));
                  m_first[i] = 1'b0;
               end
               if (never_rise && m_pos[i] > 0) begin
                  chk($sformatf("timeout_spacing_ge6[%0d]", i), 64'(cyc - m_last[i] >= 6), 64'd1);
               end
               m_last[i] = cyc;
               m_pos[i]++;
               pulses[i]++;
            end
            if (m_active[i] && m_first[i] && m_expect_at[i] < 0 && !is_tx[i]) begin
               m_expect_at[i] = cyc + 1;
            end
            m_prev_rdy[i] = rdy_exp;
         end
      end
      m_prev_dv  = reset && digest_valid;
      m_prev_dig = digest;
   end

   task automatic clear_counts();
      for (int i = 0; i < 2; i++) begin
         pulses[i]   = 0;
         dones[i]    = 0;
         overruns[i] = 0;
      end
   endtask

   task automatic send_digest(input logic [127:0] d);
      @(posedge clk);
      #1;
      digest       = d;
      digest_valid = 1'b1;
      @(posedge clk);
      #1;
      digest_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!(ready[0] && ready[1] && !busy[0] && !busy[1]) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
      end
   endtask

   task automatic wait_pulses(input int i, input int cnt, input int budget, input string name);
      int n;
      n = 0;
      while (pulses[i] < cnt && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: %0d pulses after %0d cycles, required %0d", name, pulses[i], budget, cnt);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s ready[%0d]", name, i), 64'(ready[i]), 64'd1);
         chk($sformatf("%s transmit[%0d]", name, i), 64'(transmit[i]), 64'd0);
         chk($sformatf("%s tx_byte[%0d]", name, i), 64'(tx_byte[i]), 64'd0);
         chk($sformatf("%s busy[%0d]", name, i), 64'(busy[i]), 64'd0);
         chk($sformatf("%s done[%0d]", name, i), 64'(done[i]), 64'd0);
         chk($sformatf("%s overrun[%0d]", name, i), 64'(overrun[i]), 64'd0);
      end
   endtask

   task automatic check_counts(input string name, input int hex_n, input int raw_n);
      chk($sformatf("%s pulses_hex", name), 64'(pulses[0]), 64'(hex_n));
      chk($sformatf("%s pulses_raw", name), 64'(pulses[1]), 64'(raw_n));
      chk($sformatf("%s dones_hex", name), 64'(dones[0]), 64'd1);
      chk($sformatf("%s dones_raw", name), 64'(dones[1]), 64'd1);
   endtask

   initial begin
      string lit;
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_init");
      reset = 1'b1;

      // Known-answer digest, UART busy 10 cycles per byte
      clear_counts();
      ulen = 10;
      send_digest(128'hd41d8cd98f00b204e9800998ecf8427e);
      wait_idle(2000, "kat_idle");
      check_counts("kat", 34, 16);
      lit = "d41d8cd98f00b204e9800998ecf8427e\r\n";
      for (int k = 0; k < 34; k++) chk($sformatf("kat_hex_char_%0d", k), 64'(rx[0][k]), 64'(lit[k]));
      chk("kat_raw_first", 64'(rx[1][0]), 64'hd4);
      chk("kat_raw_second", 64'(rx[1][1]), 64'h1d);
      chk("kat_raw_last", 64'(rx[1][15]), 64'h7e);

      // Second digest arriving mid-transfer must be dropped
      clear_counts();
      send_digest({$urandom, $urandom, $urandom, $urandom});
      wait_pulses(0, 5, 1000, "overrun_reach5");
      send_digest(128'h0);
      wait_idle(2000, "overrun_idle");
      check_counts("overrun", 34, 16);
      chk("overrun_pulses_hex", 64'(overruns[0]), 64'd1);
      chk("overrun_pulses_raw", 64'(overruns[1]), 64'd1);

      // UART busy when the digest arrives
      clear_counts();
      @(posedge clk);
      #1 force_busy = 1'b1;
      send_digest({$urandom, $urandom, $urandom, $urandom});
      repeat (48) @(posedge clk);
      #1 force_busy = 1'b0;
      wait_idle(2000, "busy_start_idle");
      check_counts("busy_start", 34, 16);

      // UART never acknowledges: start timeout paces the stream
      clear_counts();
      never_rise = 1'b1;
      send_digest({$urandom, $urandom, $urandom, $urandom});
      wait_idle(1000, "timeout_idle");
      never_rise = 1'b0;
      check_counts("timeout", 34, 16);

      // Reset in the middle of a transfer, then a fresh digest
      clear_counts();
      send_digest({$urandom, $urandom, $urandom, $urandom});
      wait_pulses(0, 10, 1000, "reset_mid_reach10");
      @(posedge clk);
      #3 reset = 1'b0;
      #1 check_reset_outputs("reset_mid");
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      clear_counts();
      send_digest(128'h00112233445566778899aabbccddeeff);
      wait_idle(2000, "after_reset_idle");
      check_counts("after_reset", 34, 16);
      lit = "00112233445566778899aabbccddeeff\r\n";
      for (int k = 0; k < 34; k++) chk($sformatf("after_reset_hex_char_%0d", k), 64'(rx[0][k]), 64'(lit[k]));
      chk("after_reset_raw_5", 64'(rx[1][5]), 64'h55);
      chk("after_reset_raw_15", 64'(rx[1][15]), 64'hff);

      // Random strobes and random UART busy lengths
      rand_len = 1'b1;
      for (int c = 0; c < 2500; c++) begin
         @(posedge clk);
         #1;
         digest       = {$urandom, $urandom, $urandom, $urandom};
         digest_valid = ($urandom_range(0, 49) == 0);
      end
      @(posedge clk);
      #1 digest_valid = 1'b0;
      wait_idle(3000, "random_idle");
      rand_len = 1'b0;

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/md5_digest_tx_sequencer.md
Name: md5_digest_tx_sequencer

Overview:
- Sequences transmission of a finished 128-bit MD5 digest over the shared UART transmitter, one byte at a time.
- Sits between the hash core's digest output and the UART `transmit`/`tx_byte`/`is_transmitting` interface.
- Optionally converts the digest to lowercase ASCII hex (md5sum style) and appends CR LF.
- Owns the UART TX handshake so the hash core never drives the UART directly.

Parameters:
- HEX_MODE, 1: 1 = send 32 lowercase ASCII hex chars; 0 = send 16 raw bytes.
- APPEND_CRLF, 1: 1 = append 0x0D, 0x0A after the digest.
- START_TIMEOUT, 4: cycles to wait for `is_transmitting` to rise after a `transmit` pulse before treating the byte as started.

Ports:
- clk  in  1  master clock
- reset  in  1  asynchronous, active-low reset
- digest_valid  in  1  one-cycle strobe: digest is final
- digest  in  128  digest in output order; digest[127:120] is the first byte on the wire
- is_transmitting  in  1  UART TX busy (from uart)
- ready  out  1  high in IDLE; digest_valid is accepted only when high
- transmit  out  1  one-cycle pulse to the UART
- tx_byte  out  8  byte to send; stable from the transmit pulse until the next LOAD
- busy  out  1  high from capture until the last byte completes
- done  out  1  one-cycle pulse after the final byte's UART idle is seen
- overrun  out  1  one-cycle pulse when digest_valid arrives while ready=0

Behaviour:
- Reset (reset=0, async): state=IDLE, ready=1, transmit=0, tx_byte=0x00, busy=0, done=0, overrun=0, index=0, digest register cleared.
- Character count N = (HEX_MODE ? 32 : 16) + (APPEND_CRLF ? 2 : 0). Index is 6 bits, counts 0..N-1 and never wraps.
- Character k:
  - Hex mode, k<32: nibble = digest[127-4k -: 4], high nibble first. Values 0-9 map to 0x30+n; 10-15 map to 0x61+(n-10).
  - Raw mode, k<16: digest[127-8k -: 8].
  - CR LF follow the digest when APPEND_CRLF=1.
- FSM:
  - IDLE: on digest_valid, capture digest, index=0, busy=1, go to LOAD.
  - LOAD: tx_byte=char(index). Wait until is_transmitting=0, then go to SEND.
  - SEND: transmit=1 for exactly one cycle, go to WAIT_START.
  - WAIT_START: go to WAIT_DONE when is_transmitting=1, or after START_TIMEOUT cycles.
  - WAIT_DONE: wait for is_transmitting=0.
    - If index==N-1: pulse done, busy=0, go to IDLE.
    - Else: index++, go to LOAD.
- Latency: digest_valid to first transmit pulse = 2 cycles when the UART is idle (capture, LOAD, SEND).
- No queueing. digest_valid while ready=0 is dropped, overrun pulses, and the captured digest is not altered.
- A digest_valid in the same cycle that done is asserted is dropped. ready rises the cycle after done.
- Reset asserted mid-transfer aborts immediately to reset values. The UART byte already in flight is not recalled.
- transmit is never asserted while is_transmitting=1. At most one transmit pulse per character.

Decomposition:
- Shared package md5_pkg:
  - FSM state enum (IDLE, LOAD, SEND, WAIT_START, WAIT_DONE)
  - ASCII constants: ASCII_0=0x30, ASCII_A_LC=0x61, ASCII_CR=0x0D, ASCII_LF=0x0A
  - DIGEST_W=128
- One combinational sub-module, md5_hex_char, maps a nibble to its ASCII code. The sequencer instantiates it in the char(index) mux.

Test Plan:
- Hex+CRLF: digest=0xd41d8cd98f00b204e9800998ecf8427e, UART model busy for 10 cycles per byte. Required: 34 transmit pulses, byte stream "d41d8cd98f00b204e9800998ecf8427e\r\n", one done pulse, ready=1 afterwards.
- Raw, no CRLF (HEX_MODE=0, APPEND_CRLF=0): same digest. Required: 16 pulses with bytes 0xd4, 0x1d, …, 0x7e; then done.
- Overrun: second digest_valid with digest=0x0 at byte 5. Required: overrun pulses once, the stream continues unchanged, and no restart occurs.
- Busy UART at start: is_transmitting held high for 50 cycles when digest_valid arrives. Required: no transmit pulse until it falls; the first pulse follows one cycle after it falls.
- Timeout: UART model never raises is_transmitting. Required: the next char loads after START_TIMEOUT=4 cycles, and all 34 pulses are spaced at least 6 cycles apart.
- Reset mid-transfer: reset low at char 10, released, then a new digest=0x00112233445566778899aabbccddeeff. Required: outputs at reset values immediately, then the new stream is "00112233445566778899aabbccddeeff\r\n".
